// File: rtl/ram_pkg.sv
// Shared encodings for the dual-port RAM: init FSM states and read-collision modes.
package ram_pkg;
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int RD_OLD = 0;
  localparam int RD_NEW = 1;
endpackage

// File: rtl/ram_init_ctrl.sv
// Power-up / reset clear sequencer: walks every address once writing zero, then
// hands the array over to the user ports.
module ram_init_ctrl
  import ram_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  state_e            state_q;
  logic [ADDR_W-1:0] clr_cnt_q;

  // CLEAR/READY FSM; the counter wraps back to 0 exactly as CLEAR exits.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else if (state_q == ST_CLEAR) begin
      clr_cnt_q <= clr_cnt_q + 1'b1;
      if (&clr_cnt_q) state_q <= ST_READY;
    end
  end

  // Reset itself counts as busy so requests in the reset cycle are dropped too.
  assign busy     = reset | (state_q == ST_CLEAR);
  assign clr_we   = ~reset & (state_q == ST_CLEAR);
  assign clr_addr = clr_cnt_q;

endmodule

// File: rtl/ram_dp.sv
// Simple dual-port RAM (one write port, one read port) with byte enables,
// optional output register, selectable collision behaviour and a self-clear.
module ram_dp
  import ram_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int OUT_REG = 0,
  parameter int RD_MODE = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic                rd,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [DATA_W-1:0]   rdata,
  output logic                rvalid,
  output logic                busy
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_en, rd_en;
  logic [DATA_W-1:0] rd_word;
  logic              out_vld;
  logic [DATA_W-1:0] out_data;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;

  ram_init_ctrl #(.ADDR_W(ADDR_W)) u_init (
    .clk      (clk),
    .reset    (reset),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign wr_en = wr & ~busy;
  assign rd_en = rd & ~busy;

  // Single write process: the clear port has priority over the user port.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < NB; b++)
        if (wbe[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  // Read word; in write-first mode a same-address write is forwarded bytewise.
  always_comb begin
    rd_word = mem[raddr];
    if (RD_MODE == RD_NEW && wr_en && waddr == raddr) begin
      for (int b = 0; b < NB; b++)
        if (wbe[b]) rd_word[8*b +: 8] = wdata[8*b +: 8];
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_W-1:0] s1_data_q;
      logic              s1_vld_q;

      // Extra pipeline stage between the array read and the output register.
      always_ff @(posedge clk) begin
        if (reset) s1_vld_q <= 1'b0;
        else       s1_vld_q <= rd_en;
        if (rd_en) s1_data_q <= rd_word;
      end

      assign out_vld  = s1_vld_q;
      assign out_data = s1_data_q;
    end else begin : g_noreg
      assign out_vld  = rd_en;
      assign out_data = rd_word;
    end
  endgenerate

  // Output register: only a delivered result updates rdata, otherwise it holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= out_vld;
      if (out_vld) rdata_q <= out_data;
    end
  end

  // A result already registered when reset arrives is discarded, not shown.
  assign rvalid = rvalid_q & ~reset;
  assign rdata  = rdata_q;

endmodule
